// File: rtl/piradip_axis_sample_capture_pkg.sv
// Shared types and helpers for the AXI-stream sample capture block.
package piradip_capture_pkg;

   localparam int unsigned CAP_STREAM_WIDTH = 256;
   localparam int unsigned LANES            = CAP_STREAM_WIDTH / 32;
   localparam int unsigned LANE_SEL_W       = $clog2(LANES);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARMED   = 2'd1,
      CAPTURE = 2'd2,
      DONE    = 2'd3
   } cap_state_e;

   // Pick one 32-bit lane out of a stream beat; lane 0 is the least significant word.
   function automatic logic [31:0] lane_select(input logic [CAP_STREAM_WIDTH-1:0] row,
                                               input logic [LANE_SEL_W-1:0]       lane);
      return row[{lane, 5'd0} +: 32];
   endfunction

endpackage

// File: rtl/piradip_axis_sample_capture_if.sv
// AXI-stream beat channel between a sample producer and the capture sink.
interface piradip_axis_sample_capture_if #(
   parameter int unsigned STREAM_WIDTH = 256
);
   logic [STREAM_WIDTH-1:0] tdata;
   logic                    tvalid;
   logic                    tready;
   logic                    tlast;

   modport master (output tdata, output tvalid, output tlast, input tready);
   modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/piradip_axis_sample_capture_ram.sv
// Capture storage: one write port and a read-first, lane-muxed registered read port.
module piradip_capture_ram
   import piradip_capture_pkg::*;
#(
   parameter int unsigned STREAM_WIDTH = CAP_STREAM_WIDTH,
   parameter int unsigned DEPTH_WORDS  = 32
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              we,
   input  logic [$clog2(DEPTH_WORDS)-1:0]    wr_addr,
   input  logic [STREAM_WIDTH-1:0]           wr_data,
   input  logic                              rd_en,
   input  logic [$clog2(DEPTH_WORDS)-1:0]    rd_slot,
   input  logic [$clog2(STREAM_WIDTH/32)-1:0] rd_lane,
   output logic [31:0]                       rd_data
);

   logic [STREAM_WIDTH-1:0] mem [DEPTH_WORDS];

   // Beat storage; the array carries no reset so it maps onto block RAM.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[wr_addr] <= wr_data;
      end
   end

   // Registered lane read; sees pre-write contents when the same slot is written this edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_data <= '0;
      end else if (rd_en) begin
         rd_data <= lane_select(CAP_STREAM_WIDTH'(mem[rd_slot]), LANE_SEL_W'(rd_lane));
      end
   end

endmodule

// File: rtl/piradip_axis_sample_capture.sv
// Stream sink that records a one-shot or ring window of beats for host readback.
module piradip_axis_sample_capture
   import piradip_capture_pkg::*;
#(
   parameter int unsigned STREAM_WIDTH = CAP_STREAM_WIDTH,
   parameter int unsigned DEPTH_WORDS  = 32,
   parameter int unsigned ADDR_WIDTH   = 10
) (
   input  logic                             clk,
   input  logic                             rst,
   piradip_axis_sample_capture_if.slave     s,
   input  logic                             start,
   input  logic                             stop,
   input  logic                             continuous,
   input  logic [$clog2(DEPTH_WORDS):0]     capture_len,
   output logic                             busy,
   output logic                             done,
   output logic [$clog2(DEPTH_WORDS)-1:0]   wr_ptr,
   output logic                             wrapped,
   output logic [$clog2(DEPTH_WORDS):0]     beats_captured,
   input  logic                             rd_en,
   input  logic [ADDR_WIDTH-1:0]            rd_addr,
   output logic [31:0]                      rd_data
);

   localparam int unsigned PTR_W  = $clog2(DEPTH_WORDS);
   localparam int unsigned CNT_W  = PTR_W + 1;
   localparam int unsigned BYTE_W = $clog2(STREAM_WIDTH / 8);
   localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH_WORDS);

   cap_state_e       state_q, state_d;
   logic             cont_q, cont_d;
   logic [CNT_W-1:0] len_q, len_d;
   logic [PTR_W-1:0] wr_ptr_d;
   logic             wrapped_d;
   logic [CNT_W-1:0] beats_d;
   logic [CNT_W-1:0] beats_inc_c;
   logic             tready_q;
   logic             accept_c;
   logic             we_c;
   logic             unused_bits;

   assign s.tready    = tready_q;
   assign accept_c    = s.tvalid & tready_q;
   assign beats_inc_c = beats_captured + CNT_W'(1);

   // Byte-lane offset bits and tlast do not affect capture.
   assign unused_bits = ^{rd_addr[1:0], s.tlast};

   // Next-state and counter update; start overrides everything else, including stop and the beat.
   always_comb begin
      state_d   = state_q;
      cont_d    = cont_q;
      len_d     = len_q;
      wr_ptr_d  = wr_ptr;
      wrapped_d = wrapped;
      beats_d   = beats_captured;
      we_c      = 1'b0;

      if (start) begin
         cont_d    = continuous;
         len_d     = (capture_len > DEPTH_CNT) ? DEPTH_CNT : capture_len;
         wr_ptr_d  = '0;
         wrapped_d = 1'b0;
         beats_d   = '0;
         if (!continuous && (capture_len == '0)) begin
            state_d = DONE;
         end else begin
            state_d = ARMED;
         end
      end else begin
         case (state_q)
            ARMED, CAPTURE: begin
               if (accept_c) begin
                  we_c     = 1'b1;
                  wr_ptr_d = wr_ptr + PTR_W'(1);
                  state_d  = CAPTURE;
                  if (cont_q && (&wr_ptr)) begin
                     wrapped_d = 1'b1;
                  end
                  if (beats_captured != DEPTH_CNT) begin
                     beats_d = beats_inc_c;
                  end
                  if (!cont_q && (beats_inc_c == len_q)) begin
                     state_d = DONE;
                  end
               end
               if (stop) begin
                  state_d = DONE;
               end
            end
            default: begin
            end
         endcase
      end
   end

   // State, latched command fields and registered status outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= IDLE;
         cont_q         <= 1'b0;
         len_q          <= '0;
         tready_q       <= 1'b0;
         busy           <= 1'b0;
         done           <= 1'b0;
         wr_ptr         <= '0;
         wrapped        <= 1'b0;
         beats_captured <= '0;
      end else begin
         state_q        <= state_d;
         cont_q         <= cont_d;
         len_q          <= len_d;
         tready_q       <= 1'b1;
         busy           <= (state_d == ARMED) || (state_d == CAPTURE);
         done           <= (state_d == DONE);
         wr_ptr         <= wr_ptr_d;
         wrapped        <= wrapped_d;
         beats_captured <= beats_d;
      end
   end

   piradip_capture_ram #(
      .STREAM_WIDTH (STREAM_WIDTH),
      .DEPTH_WORDS  (DEPTH_WORDS)
   ) u_ram (
      .clk     (clk),
      .rst     (rst),
      .we      (we_c),
      .wr_addr (wr_ptr),
      .wr_data (s.tdata),
      .rd_en   (rd_en),
      .rd_slot (rd_addr[ADDR_WIDTH-1:BYTE_W]),
      .rd_lane (rd_addr[BYTE_W-1:2]),
      .rd_data (rd_data)
   );

endmodule

// File: tb/tb_piradip_axis_sample_capture.sv
// Directed bench for the sample capture block: one-shot, ring, gaps, restart, clamp, reset.
module tb_piradip_axis_sample_capture;

   logic        clk = 1'b0;
   logic        rst;
   logic        start, stop, continuous;
   logic [5:0]  capture_len;
   logic        busy, done, wrapped;
   logic [4:0]  wr_ptr;
   logic [5:0]  beats_captured;
   logic        rd_en;
   logic [9:0]  rd_addr;
   logic [31:0] rd_data;

   int n_tests = 0;
   int n_fail  = 0;

   piradip_axis_sample_capture_if #(.STREAM_WIDTH(256)) axis ();

   piradip_axis_sample_capture #(
      .STREAM_WIDTH (256),
      .DEPTH_WORDS  (32),
      .ADDR_WIDTH   (10)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .s              (axis),
      .start          (start),
      .stop           (stop),
      .continuous     (continuous),
      .capture_len    (capture_len),
      .busy           (busy),
      .done           (done),
      .wr_ptr         (wr_ptr),
      .wrapped        (wrapped),
      .beats_captured (beats_captured),
      .rd_en          (rd_en),
      .rd_addr        (rd_addr),
      .rd_data        (rd_data)
   );

   always #5 clk = ~clk;

   // Beat k carries {k, lane} in every 32-bit lane.
   function automatic logic [255:0] pat(input int k);
      logic [255:0] d;
      d = '0;
      for (int j = 0; j < 8; j++) begin
         d[j*32 +: 32] = {16'(k), 16'(j)};
      end
      return d;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic beat(input logic v, input int k);
      axis.tvalid = v;
      axis.tdata  = pat(k);
      @(negedge clk);
   endtask

   task automatic rd(input logic [9:0] a);
      rd_addr = a;
      rd_en   = 1'b1;
      @(negedge clk);
      rd_en   = 1'b0;
   endtask

   task automatic arm(input logic cont, input logic [5:0] len);
      start       = 1'b1;
      continuous  = cont;
      capture_len = len;
      @(negedge clk);
      start       = 1'b0;
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; stop = 1'b0; continuous = 1'b0; capture_len = '0;
      rd_en = 1'b0; rd_addr = '0;
      axis.tvalid = 1'b0; axis.tdata = '0; axis.tlast = 1'b0;

      // Reset values
      @(negedge clk);
      chk("rst_tready", 32'(axis.tready), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_wr_ptr", 32'(wr_ptr), 32'd0);
      chk("rst_wrapped", 32'(wrapped), 32'd0);
      chk("rst_beats", 32'(beats_captured), 32'd0);
      chk("rst_rd_data", rd_data, 32'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("tready_after_rst", 32'(axis.tready), 32'd1);

      // stop while idle does nothing
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
      chk("idle_stop_done", 32'(done), 32'd0);
      chk("idle_stop_busy", 32'(busy), 32'd0);

      // One-shot, length 4
      arm(1'b0, 6'd4);
      chk("os_armed_busy", 32'(busy), 32'd1);
      for (int k = 0; k < 10; k++) begin
         beat(1'b1, k);
         if (k == 2) begin
            chk("os_k2_done", 32'(done), 32'd0);
            chk("os_k2_beats", 32'(beats_captured), 32'd3);
         end
         if (k == 3) begin
            chk("os_k3_done", 32'(done), 32'd1);
            chk("os_k3_busy", 32'(busy), 32'd0);
         end
      end
      axis.tvalid = 1'b0;
      chk("os_beats", 32'(beats_captured), 32'd4);
      chk("os_wr_ptr", 32'(wr_ptr), 32'd4);
      rd(10'h024);
      chk("os_rd_024", rd_data, 32'h0001_0001);
      rd(10'h07C);
      chk("os_rd_07c", rd_data, 32'h0003_0007);
      rd_addr = 10'h000;
      @(negedge clk);
      chk("rd_hold", rd_data, 32'h0003_0007);

      // Continuous ring, 40 beats then stop
      arm(1'b1, 6'd0);
      chk("ring_busy", 32'(busy), 32'd1);
      chk("ring_cleared_beats", 32'(beats_captured), 32'd0);
      chk("ring_cleared_done", 32'(done), 32'd0);
      for (int k = 0; k < 40; k++) begin
         beat(1'b1, k);
         if (k == 30) begin
            chk("ring_k30_wrapped", 32'(wrapped), 32'd0);
            chk("ring_k30_wr_ptr", 32'(wr_ptr), 32'd31);
         end
         if (k == 31) begin
            chk("ring_k31_wrapped", 32'(wrapped), 32'd1);
            chk("ring_k31_wr_ptr", 32'(wr_ptr), 32'd0);
         end
      end
      axis.tvalid = 1'b0;
      chk("ring_busy_before_stop", 32'(busy), 32'd1);
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
      chk("ring_done", 32'(done), 32'd1);
      chk("ring_wrapped", 32'(wrapped), 32'd1);
      chk("ring_wr_ptr", 32'(wr_ptr), 32'd8);
      chk("ring_beats", 32'(beats_captured), 32'd32);
      rd(10'h000);
      chk("ring_slot0", rd_data, 32'h0020_0000);
      rd(10'h108);
      chk("ring_slot8_l2", rd_data, 32'h0008_0002);
      rd(10'h0E0);
      chk("ring_slot7", rd_data, 32'h0027_0000);

      // One-shot length 3 with gaps in tvalid
      arm(1'b0, 6'd3);
      for (int i = 0; i < 6; i++) begin
         beat((i % 2) == 0, 50 + i);
         if (i == 3) begin
            chk("gap_i3_beats", 32'(beats_captured), 32'd2);
            chk("gap_i3_done", 32'(done), 32'd0);
         end
         if (i == 4) begin
            chk("gap_i4_done", 32'(done), 32'd1);
            chk("gap_i4_wr_ptr", 32'(wr_ptr), 32'd3);
         end
      end
      axis.tvalid = 1'b0;
      rd(10'h000);
      chk("gap_slot0", rd_data, 32'h0032_0000);
      rd(10'h020);
      chk("gap_slot1", rd_data, 32'h0034_0000);
      rd(10'h040);
      chk("gap_slot2", rd_data, 32'h0036_0000);

      // Restart mid-capture, with a simultaneous stop and beat
      arm(1'b0, 6'd10);
      for (int k = 60; k < 65; k++) begin
         beat(1'b1, k);
      end
      chk("rs_pre_beats", 32'(beats_captured), 32'd5);
      start = 1'b1; stop = 1'b1; continuous = 1'b0; capture_len = 6'd10;
      beat(1'b1, 99);
      start = 1'b0; stop = 1'b0;
      chk("rs_busy", 32'(busy), 32'd1);
      chk("rs_done", 32'(done), 32'd0);
      chk("rs_beats", 32'(beats_captured), 32'd0);
      chk("rs_wr_ptr", 32'(wr_ptr), 32'd0);
      beat(1'b1, 70);
      axis.tvalid = 1'b0;
      chk("rs_next_beats", 32'(beats_captured), 32'd1);
      chk("rs_next_wr_ptr", 32'(wr_ptr), 32'd1);
      rd(10'h000);
      chk("rs_slot0", rd_data, 32'h0046_0000);
      rd(10'h020);
      chk("rs_slot1_old", rd_data, 32'h003D_0000);
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
      chk("rs_stop_done", 32'(done), 32'd1);

      // Zero-length one-shot goes straight to done without writing
      start = 1'b1; continuous = 1'b0; capture_len = 6'd0;
      beat(1'b1, 200);
      start = 1'b0;
      chk("z_done", 32'(done), 32'd1);
      chk("z_busy", 32'(busy), 32'd0);
      chk("z_beats", 32'(beats_captured), 32'd0);
      beat(1'b1, 201);
      axis.tvalid = 1'b0;
      chk("z_beats_hold", 32'(beats_captured), 32'd0);
      chk("z_wr_ptr", 32'(wr_ptr), 32'd0);
      rd(10'h000);
      chk("z_slot0_untouched", rd_data, 32'h0046_0000);

      // Length above depth clamps to 32; read colliding with a write returns old data
      arm(1'b0, 6'd40);
      rd_addr = 10'h000;
      rd_en   = 1'b1;
      beat(1'b1, 300);
      rd_en   = 1'b0;
      chk("coll_read_first", rd_data, 32'h0046_0000);
      for (int k = 301; k < 332; k++) begin
         beat(1'b1, k);
      end
      axis.tvalid = 1'b0;
      chk("clamp_done", 32'(done), 32'd1);
      chk("clamp_beats", 32'(beats_captured), 32'd32);
      chk("clamp_wr_ptr", 32'(wr_ptr), 32'd0);
      chk("clamp_wrapped", 32'(wrapped), 32'd0);
      rd(10'h000);
      chk("clamp_slot0", rd_data, 32'h012C_0000);
      rd(10'h3FC);
      chk("clamp_slot31_l7", rd_data, 32'h014B_0007);

      // Asynchronous reset in the middle of a ring capture
      arm(1'b1, 6'd0);
      beat(1'b1, 400);
      beat(1'b1, 401);
      beat(1'b1, 402);
      chk("ar_pre_wr_ptr", 32'(wr_ptr), 32'd3);
      #2;
      rst = 1'b1;
      #1;
      chk("ar_tready", 32'(axis.tready), 32'd0);
      chk("ar_busy", 32'(busy), 32'd0);
      chk("ar_done", 32'(done), 32'd0);
      chk("ar_wr_ptr", 32'(wr_ptr), 32'd0);
      chk("ar_beats", 32'(beats_captured), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      axis.tvalid = 1'b0;
      @(negedge clk);
      chk("ar_tready_back", 32'(axis.tready), 32'd1);
      chk("ar_idle_busy", 32'(busy), 32'd0);
      arm(1'b0, 6'd1);
      beat(1'b1, 500);
      axis.tvalid = 1'b0;
      chk("ar_resume_done", 32'(done), 32'd1);
      chk("ar_resume_beats", 32'(beats_captured), 32'd1);
      rd(10'h000);
      chk("ar_resume_slot0", rd_data, 32'h01F4_0000);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
